// File: rtl/conv_encoder_punct.sv
// -----------------------------------------------------------------------------
// conv_encoder_punct
//
// Rate-1/2 convolutional encoder for the TX bit path, followed by 802.11
// puncturing to rate 1/2, 2/3 or 3/4 and a two-entry serialiser. It sits between
// the scrambler and the interleaver. Every accepted input bit yields one or two
// coded bits, and those leave one per cycle under valid/ready flow control.
//
// A frame starts on an accepted bit with in_first set. That bit resets the
// encoder state and the puncture phase, and latches the rate select for the
// whole frame. Coded bits of an earlier frame that are still buffered drain
// first, in order.
//
// Parameters
//   K    constraint length; the encoder state holds K-1 past bits
//   G0   generator polynomial for coded output A (MSB taps the current bit)
//   G1   generator polynomial for coded output B (MSB taps the current bit)
//
// Ports
//   clk        in   1  clock; all state changes on the rising edge
//   rst        in   1  synchronous reset, active high
//   rate       in   2  00=1/2, 01=2/3, 10=3/4, 11=1/2; sampled on an accepted in_first
//   in_valid   in   1  input bit valid
//   in_ready   out  1  encoder accepts an input bit this cycle
//   in_bit     in   1  uncoded data bit
//   in_first   in   1  first bit of a frame (qualified by in_valid)
//   in_last    in   1  last bit of a frame (qualified by in_valid)
//   out_valid  out  1  coded bit valid
//   out_ready  in   1  downstream accepts the coded bit
//   out_bit    out  1  coded bit
//   out_last   out  1  final coded bit of the frame
// -----------------------------------------------------------------------------
module conv_encoder_punct #(
  parameter int unsigned    K  = 7,
  parameter logic [K-1:0]   G0 = 7'o133,
  parameter logic [K-1:0]   G1 = 7'o171
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] rate,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_first,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_last
);

  // Rate-select codes. 2'b11 does not appear here because it is folded into 1/2.
  localparam logic [1:0] RATE_1_2 = 2'b00;
  localparam logic [1:0] RATE_2_3 = 2'b01;
  localparam logic [1:0] RATE_3_4 = 2'b10;

  // Fill level of the output serialiser.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [K-2:0] r_sr;       // past input bits; r_sr[K-2] is the most recent one
  logic [1:0]   r_ph;       // puncture phase of the next non-first bit
  logic [1:0]   r_rate_q;   // normalised rate of the current frame
  logic         r_last_q;   // buffered bits belong to a frame's last input bit
  logic [1:0]   r_hold;     // r_hold[0] is on out_bit; r_hold[1] goes out next
  buf_state_t   r_buf;      // number of valid entries in r_hold

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic         w_fire_in;
  logic         w_fire_out;
  logic [K-1:0] w_window;   // {current bit, past bits}, aligned with G0/G1
  logic         w_a;
  logic         w_b;
  logic [1:0]   w_rate_eff; // rate that applies to the bit being accepted
  logic [1:0]   w_ph_eff;   // phase that applies to the bit being accepted
  logic [1:0]   w_ph_next;
  logic [1:0]   w_kept;     // kept coded bits; w_kept[0] is sent first
  logic         w_kept_two; // 1: both A and B are kept, 0: only w_kept[0]
  buf_state_t   w_buf_next;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  // A new bit may load only when the buffer will be empty at the next edge:
  // it is already empty, or its last entry leaves this cycle. Buffering a
  // third bit would need another hold stage, and rate 1/2 cannot use it
  // anyway because each input bit already takes two output cycles.
  assign in_ready   = ~rst & ((r_buf == BUF_EMPTY) |
                              ((r_buf == BUF_ONE) & out_ready));
  assign out_valid  = ~rst & (r_buf != BUF_EMPTY);
  assign out_bit    = ~rst & r_hold[0];
  assign out_last   = out_valid & r_last_q & (r_buf == BUF_ONE);

  assign w_fire_in  = in_valid & in_ready;
  assign w_fire_out = out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------------
  // A frame-start bit behaves as if all earlier bits were zero. The
  // registered state is never cleared separately, so a new frame can follow
  // the previous one directly without an idle cycle.
  assign w_window = in_first ? {in_bit, {(K-1){1'b0}}} : {in_bit, r_sr};
  assign w_a      = ^(w_window & G0);
  assign w_b      = ^(w_window & G1);

  // ---------------------------------------------------------------------------
  // Puncturing
  // ---------------------------------------------------------------------------
  // NOTE: an always_comb block assigns every output before any branch. A
  // path that leaves an output unassigned would make synthesis infer a latch.
  always_comb begin
    w_rate_eff = in_first ? rate : r_rate_q;
    if (w_rate_eff == 2'b11) begin
      w_rate_eff = RATE_1_2;
    end
    w_ph_eff   = in_first ? 2'd0 : r_ph;

    w_kept     = {w_b, w_a};
    w_kept_two = 1'b1;
    w_ph_next  = 2'd0;

    case (w_rate_eff)
      RATE_2_3: begin
        // Pattern A,B | A
        if (w_ph_eff == 2'd0) begin
          w_ph_next = 2'd1;
        end else begin
          w_kept     = {1'b0, w_a};
          w_kept_two = 1'b0;
        end
      end
      RATE_3_4: begin
        // Pattern A,B | A | B
        case (w_ph_eff)
          2'd0: begin
            w_ph_next = 2'd1;
          end
          2'd1: begin
            w_kept     = {1'b0, w_a};
            w_kept_two = 1'b0;
            w_ph_next  = 2'd2;
          end
          default: begin
            w_kept     = {1'b0, w_b};
            w_kept_two = 1'b0;
          end
        endcase
      end
      default: ; // rate 1/2 keeps both bits and has only one phase
    endcase
  end

  // ---------------------------------------------------------------------------
  // Encoder state, phase and frame context
  // ---------------------------------------------------------------------------
  // NOTE: registers take non-blocking assignments, so every block reads the
  // values from before the clock edge, whatever order the blocks run in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr     <= '0;
      r_ph     <= 2'd0;
      r_rate_q <= RATE_1_2;
      r_last_q <= 1'b0;
    end else if (w_fire_in) begin
      r_sr     <= w_window[K-1:1];
      r_ph     <= w_ph_next;
      r_rate_q <= w_rate_eff;  // does not change except on a frame-start bit
      r_last_q <= in_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Output serialiser: state register and next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf <= BUF_EMPTY;
    end else begin
      r_buf <= w_buf_next;
    end
  end

  always_comb begin
    w_buf_next = r_buf;
    if (w_fire_in) begin
      // A load only happens on an empty buffer or together with its final
      // drain, so the new fill level is just the number of kept bits.
      w_buf_next = w_kept_two ? BUF_TWO : BUF_ONE;
    end else if (w_fire_out) begin
      case (r_buf)
        BUF_TWO: w_buf_next = BUF_ONE;
        default: w_buf_next = BUF_EMPTY;
      endcase
    end
  end

  // Hold data. Clearing it on reset keeps out_bit at 0 after a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= 2'b00;
    end else if (w_fire_in) begin
      r_hold <= w_kept;
    end else if (w_fire_out && (r_buf == BUF_TWO)) begin
      r_hold <= {1'b0, r_hold[1]};
    end
  end

endmodule

// File: tb/tb_conv_encoder_punct.sv
// -----------------------------------------------------------------------------
// Testbench for conv_encoder_punct.
//
// The reference model encodes from the generator polynomials and the bit
// history of the current frame, and applies the puncture table per phase.
// Expected coded bits go into a queue, and a monitor compares the DUT with it
// on every cycle. Directed frames also compare the captured stream with
// hand-derived literals.
// -----------------------------------------------------------------------------
module tb_conv_encoder_punct;

  localparam int         K  = 7;
  localparam logic [6:0] G0 = 7'o133;
  localparam logic [6:0] G1 = 7'o171;

  typedef struct packed {
    logic b;
    logic l;
  } coded_t;
  typedef logic lq_t[$];

  logic       clk;
  logic       rst;
  logic [1:0] rate;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_first;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic       out_last;

  int     n_checks = 0;
  int     n_fail   = 0;
  coded_t exp_q[$];
  bit     m_hist[$];
  int     m_idx  = 0;
  int     m_rate = 0;
  logic   cap_b[$];
  logic   cap_l[$];
  int     n_in_last  = 0;
  int     n_out_last = 0;
  int     ready_mode = 0;   // 0: always ready, 1: random, 2: ready_val
  logic   ready_val  = 1'b1;

  conv_encoder_punct #(.K(K), .G0(G0), .G1(G1)) dut (
    .clk       (clk),
    .rst       (rst),
    .rate      (rate),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_last  (out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] vec_of(input lq_t q);
    logic [31:0] v = '0;
    foreach (q[i]) v = {v[30:0], q[i]};
    return v;
  endfunction

  // Reference model: consumes one accepted input bit.
  function automatic void model_accept(input logic b, input logic first,
                                       input logic last, input logic [1:0] r);
    logic   a_bit = 1'b0;
    logic   b_bit = 1'b0;
    logic   d;
    int     p;
    int     ph;
    coded_t c;
    if (first) begin
      m_hist.delete();
      m_idx  = 0;
      m_rate = (r == 2'b11) ? 0 : int'(r);
    end
    for (int j = 0; j < K; j++) begin
      // d is the input bit j steps in the past; bits before the frame are 0.
      if (j == 0)                d = b;
      else if (m_hist.size() >= j) d = m_hist[m_hist.size() - j];
      else                       d = 1'b0;
      a_bit ^= G0[K-1-j] & d;
      b_bit ^= G1[K-1-j] & d;
    end
    p  = m_rate + 1;            // puncture period: 1, 2 or 3
    ph = m_idx % p;
    case (ph)
      0: begin
        c.b = a_bit; c.l = 1'b0; exp_q.push_back(c);
        c.b = b_bit; c.l = last; exp_q.push_back(c);
      end
      1: begin
        c.b = a_bit; c.l = last; exp_q.push_back(c);
      end
      default: begin
        c.b = b_bit; c.l = last; exp_q.push_back(c);
      end
    endcase
    m_hist.push_back(b);
    m_idx++;
    if (last) n_in_last++;
  endfunction

  // out_ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = ready_val;
      endcase
    end
  end

  // Monitor: compares against the model on every cycle
  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_bit", out_bit, 0);
      exp_q.delete();
      m_hist.delete();
      m_idx  = 0;
      m_rate = 0;
    end else begin
      check("out_valid", out_valid, exp_q.size() != 0);
      check("in_ready", in_ready,
            (exp_q.size() == 0) || ((exp_q.size() == 1) && out_ready));
      if (out_valid && exp_q.size() != 0) begin
        check("out_bit", out_bit, exp_q[0].b);
        check("out_last", out_last, exp_q[0].l);
      end else begin
        check("out_last_idle", out_last, 0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        cap_b.push_back(out_bit);
        cap_l.push_back(out_last);
        if (out_last) n_out_last++;
      end
      if (in_valid && in_ready) model_accept(in_bit, in_first, in_last, rate);
    end
  end

  // Presents one bit and waits (bounded) until it is accepted.
  task automatic send_bit(input logic b, input logic first, input logic last,
                          input logic [1:0] r);
    int waited = 0;
    bit ok     = 1'b0;
    in_bit   = b;
    in_first = first;
    in_last  = last;
    rate     = r;
    in_valid = 1'b1;
    while (waited < 200) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    check("send_accepted", 32'(ok), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(posedge clk);
      w++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_capture();
    cap_b.delete();
    cap_l.delete();
  endtask

  initial begin
    logic [6:0] t1_bits;
    logic [5:0] t2_bits;
    logic [3:0] t3_bits;

    rst      = 1'b1;
    rate     = 2'b00;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check("reset_out_bit", out_bit, 0);
    @(posedge clk);
    #1;

    // T1: impulse response at rate 1/2
    clear_capture();
    t1_bits = 7'b1000000;
    for (int i = 0; i < 7; i++)
      send_bit(t1_bits[6-i], i == 0, i == 6, 2'b00);
    drain();
    check("t1_len", cap_b.size(), 14);
    check("t1_bits", vec_of(cap_b), 32'b11011111001011);
    check("t1_last", vec_of(cap_l), 32'b00000000000001);

    // T2: rate 3/4
    clear_capture();
    t2_bits = 6'b100000;
    for (int i = 0; i < 6; i++)
      send_bit(t2_bits[5-i], i == 0, i == 5, 2'b10);
    drain();
    check("t2_len", cap_b.size(), 8);
    check("t2_bits", vec_of(cap_b), 32'b11011100);
    check("t2_last", vec_of(cap_l), 32'b00000001);

    // T3: rate 2/3. Rate changes on non-first bits are ignored. Then a new
    //     one-bit frame starts with no in_last on the old frame.
    clear_capture();
    t3_bits = 4'b1000;
    for (int i = 0; i < 4; i++)
      send_bit(t3_bits[3-i], i == 0, 1'b0, (i == 0) ? 2'b01 : 2'b10);
    drain();
    check("t3_len", cap_b.size(), 6);
    check("t3_bits", vec_of(cap_b), 32'b110111);
    check("t3_last", vec_of(cap_l), 32'b000000);
    clear_capture();
    send_bit(1'b1, 1'b1, 1'b1, 2'b00);
    drain();
    check("t3b_bits", vec_of(cap_b), 32'b11);
    check("t3b_last", vec_of(cap_l), 32'b01);

    // T4: backpressure holds the output stable
    clear_capture();
    ready_mode = 2;
    ready_val  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fork
      begin
        send_bit(1'b1, 1'b1, 1'b0, 2'b00);
        send_bit(1'b0, 1'b0, 1'b1, 2'b00);
      end
      begin
        int w = 0;
        while (!out_valid && w < 50) begin
          @(negedge clk);
          w++;
        end
        for (int i = 0; i < 5; i++) begin
          check("t4_hold_valid", out_valid, 1);
          check("t4_hold_bit", out_bit, 1);
          check("t4_hold_in_ready", in_ready, 0);
          @(negedge clk);
        end
        ready_val = 1'b1;
      end
    join
    drain();
    ready_mode = 0;
    check("t4_bits", vec_of(cap_b), 32'b1101);
    check("t4_last", vec_of(cap_l), 32'b0001);

    // T5: reset while two coded bits are buffered
    ready_mode = 2;
    ready_val  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_bit(1'b1, 1'b1, 1'b0, 2'b00);
    check("t5_pre_valid", out_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    check("t5_out_valid", out_valid, 0);
    check("t5_in_ready", in_ready, 1);
    check("t5_out_bit", out_bit, 0);
    @(posedge clk);
    #1;
    clear_capture();
    send_bit(1'b1, 1'b1, 1'b1, 2'b00);
    drain();
    check("t5_bits", vec_of(cap_b), 32'b11);

    // T6: random frames at all rates with random backpressure
    ready_mode = 1;
    n_in_last  = 0;
    n_out_last = 0;
    for (int r = 0; r < 4; r++) begin
      for (int f = 0; f < 6; f++) begin
        int len  = int'($urandom_range(1, 16));
        bit drop = ($urandom_range(0, 7) == 0);
        for (int i = 0; i < len; i++) begin
          send_bit(1'($urandom_range(0, 1)), i == 0,
                   (i == len - 1) && !drop,
                   (i == 0) ? 2'(r) : 2'($urandom_range(0, 3)));
        end
      end
    end
    ready_mode = 0;
    drain();
    check("t6_last_count", n_out_last, n_in_last);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
